// File: rtl/wb_write_queue.sv
// wb_write_queue
// Writeback queue that sits in front of the 32x32 register file write port.
// It accepts writeback requests from the ALU, load and branch-and-link paths
// through a valid/ready handshake. Requests are held in an in-order circular
// buffer, and at most one is retired per cycle into the register file.
// Decode can look up pending writes combinationally, so it can forward a
// value or stall.
//
// Optional build macro: WBQ_BYPASS_EN
//   When defined, a request that arrives while the queue is empty (and there
//   is no stall or flush) is driven straight onto rf_wr_* in the same cycle.
//   It is not stored, and lookup never reports it.
//
// Ports:
//   clock, reset         system clock; synchronous active-high reset
//   flush                synchronous discard of all queued entries
//   in_valid/in_ready    request handshake
//   in_addr/in_data      destination register and value
//   in_link              redirect the write to LINK_REG
//   rf_wr_en/addr/data   register file write port
//   rf_stall             register file busy; the head entry is held
//   lookup_addr          register index queried by decode
//   lookup_hit/data      youngest pending write to lookup_addr
//   count                number of valid entries
module wb_write_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int LINK_REG = 31
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_link,
  output logic                     rf_wr_en,
  output logic [ADDR_W-1:0]        rf_wr_addr,
  output logic [DATA_W-1:0]        rf_wr_data,
  input  logic                     rf_stall,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic [ADDR_W-1:0] addr_eff;
  logic              not_empty;
  logic              pop;
  logic              push;
  logic              bypass;

  assign addr_eff  = in_link ? ADDR_W'(LINK_REG) : in_addr;
  assign not_empty = (count != '0);
  assign in_ready  = (count < FULL) && !flush;

  // A write presented on the reset edge would land in the register file
  // after the queue has already forgotten it, so reset also blocks retirement.
  assign pop = not_empty && !rf_stall && !flush && !reset;

`ifdef WBQ_BYPASS_EN
  assign bypass = !not_empty && !rf_stall && !flush && !reset && in_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = in_valid && in_ready && !bypass;

  // Address and data stay on the head entry while stalled. Only the
  // strobe drops.
  always_comb begin
    rf_wr_en   = pop || bypass;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    if (not_empty) begin
      rf_wr_addr = q_addr[head];
      rf_wr_data = q_data[head];
    end else if (bypass) begin
      rf_wr_addr = addr_eff;
      rf_wr_data = in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      q_addr[tail] <= addr_eff;
      q_data[tail] <= in_data;
    end
  end

  // Scan from oldest to youngest so that the last match wins. An entry that
  // retires this cycle is still included, because the register file shows
  // its value only from the next cycle on.
  logic [PTR_W-1:0] idx;
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (q_addr[idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = q_data[idx];
      end
    end
  end

endmodule
